// File: rtl/iob_iob2wishbone.sv
// IOb-bus slave to classic Wishbone master bridge.
// Each accepted IOb request becomes one Wishbone single cycle. The cycle ends
// on ack, on err, or when the optional cycle counter expires.
module iob_iob2wishbone #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                cke_i,
    input  logic                iob_avalid_i,
    input  logic [ADDR_W-1:0]   iob_addr_i,
    input  logic [DATA_W-1:0]   iob_wdata_i,
    input  logic [DATA_W/8-1:0] iob_wstrb_i,
    output logic                iob_ready_o,
    output logic                iob_rvalid_o,
    output logic [DATA_W-1:0]   iob_rdata_o,
    output logic                iob_err_o,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    output logic                wb_we_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i
);

    localparam int STRB_W = DATA_W / 8;
    // Keep the counter at least one bit wide so TIMEOUT=0 still elaborates.
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // The counter holds (stb cycles already spent); the last allowed cycle is TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [ADDR_W-1:0]   adr, adr_nxt;
    logic [DATA_W-1:0]   dat, dat_nxt;
    logic [STRB_W-1:0]   sel, sel_nxt;
    logic                we, we_nxt;
    logic                rvalid, rvalid_nxt;
    logic                err, err_nxt;
    logic [DATA_W-1:0]   rdata, rdata_nxt;
    logic                timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

    // Next-state and next register values; error beats ack, ack beats timeout.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        adr_nxt    = adr;
        dat_nxt    = dat;
        sel_nxt    = sel;
        we_nxt     = we;
        rvalid_nxt = 1'b0;
        err_nxt    = 1'b0;
        rdata_nxt  = rdata;
        case (state)
            IDLE: begin
                if (iob_avalid_i) begin
                    state_nxt = BUS;
                    cnt_nxt   = '0;
                    adr_nxt   = iob_addr_i;
                    dat_nxt   = iob_wdata_i;
                    we_nxt    = |iob_wstrb_i;
                    sel_nxt   = (|iob_wstrb_i) ? iob_wstrb_i : {STRB_W{1'b1}};
                end
            end
            BUS: begin
                cnt_nxt = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
                if (wb_err_i || (!wb_ack_i && timeout_hit)) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                    if (!we) begin
                        rvalid_nxt = 1'b1;
                        rdata_nxt  = {DATA_W{1'b1}};
                    end
                end else if (wb_ack_i) begin
                    state_nxt = IDLE;
                    if (!we) begin
                        rvalid_nxt = 1'b1;
                        rdata_nxt  = wb_dat_i;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; frozen while the clock enable is low.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state <= IDLE;
        end else if (cke_i) begin
            state <= state_nxt;
        end
    end

    // Request, counter and response registers; frozen while the clock enable is low.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cnt    <= '0;
            adr    <= '0;
            dat    <= '0;
            sel    <= '0;
            we     <= 1'b0;
            rvalid <= 1'b0;
            err    <= 1'b0;
            rdata  <= '0;
        end else if (cke_i) begin
            cnt    <= cnt_nxt;
            adr    <= adr_nxt;
            dat    <= dat_nxt;
            sel    <= sel_nxt;
            we     <= we_nxt;
            rvalid <= rvalid_nxt;
            err    <= err_nxt;
            rdata  <= rdata_nxt;
        end
    end

    assign iob_ready_o  = (state == IDLE);
    assign wb_cyc_o     = (state == BUS);
    assign wb_stb_o     = (state == BUS);
    assign wb_adr_o     = adr;
    assign wb_dat_o     = dat;
    assign wb_sel_o     = sel;
    assign wb_we_o      = we;
    assign iob_rvalid_o = rvalid;
    assign iob_err_o    = err;
    assign iob_rdata_o  = rdata;

endmodule

// File: tb/tb_iob_iob2wishbone.sv
// Directed and randomized bench for the IOb-to-Wishbone bridge, using a
// memory-backed Wishbone slave and an independent transaction-level model.
module tb_iob_iob2wishbone;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        cke = 1'b1;
    logic        avalid = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        ready, rvalid, err;
    logic [31:0] rdata;
    logic [31:0] wb_adr, wb_dat_o, wb_dat_i = '0;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb;
    logic        wb_ack = 1'b0, wb_err = 1'b0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem     [16];   // Wishbone slave storage
    logic [31:0] ref_mem [16];   // model of what the slave should contain
    logic [31:0] exp_rdata = '0; // model of iob_rdata_o

    iob_iob2wishbone #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
        .iob_avalid_i(avalid), .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
        .iob_ready_o(ready), .iob_rvalid_o(rvalid), .iob_rdata_o(rdata), .iob_err_o(err),
        .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack), .wb_err_i(wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Slave answers with ack: commit the write through sel, or present read data.
    task automatic slave_ack();
        int idx = int'(wb_adr[5:2]);
        wb_ack = 1'b1;
        wb_dat_i = mem[idx];
        if (wb_we)
            for (int b = 0; b < 4; b++)
                if (wb_sel[b]) mem[idx][8*b +: 8] = wb_dat_o[8*b +: 8];
    endtask

    // One complete transfer: waits = wait states before the slave answers.
    task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input int waits, input bit use_err);
        bit is_rd, timed_out, exp_err;
        int stb_cycles, idx;
        logic [31:0] mask;
        is_rd      = (ws == 4'b0);
        timed_out  = (waits + 1 > TO);
        stb_cycles = timed_out ? TO : waits + 1;
        exp_err    = use_err || timed_out;
        idx        = int'(a[5:2]);
        @(negedge clk);
        chk("ready_before", {31'b0, ready}, 32'd1);
        avalid = 1'b1; addr = a; wdata = wd; wstrb = ws;
        @(posedge clk);
        #1;
        avalid = 1'b0; addr = $urandom(); wdata = $urandom(); wstrb = 4'($urandom());
        for (int k = 1; k <= stb_cycles; k++) begin
            @(negedge clk);
            chk("stb_high", {31'b0, wb_stb}, 32'd1);
            chk("cyc_high", {31'b0, wb_cyc}, 32'd1);
            chk("ready_busy", {31'b0, ready}, 32'd0);
            chk("we", {31'b0, wb_we}, {31'b0, !is_rd});
            chk("sel", {28'b0, wb_sel}, is_rd ? 32'hF : {28'b0, ws});
            chk("adr", wb_adr, a);
            if (!is_rd) chk("dat_o", wb_dat_o, wd);
            if (!timed_out && k == stb_cycles) begin
                if (use_err) wb_err = 1'b1;
                else         slave_ack();
            end
        end
        @(posedge clk);
        #1;
        wb_ack = 1'b0; wb_err = 1'b0;
        if (is_rd) exp_rdata = exp_err ? 32'hFFFF_FFFF : ref_mem[idx];
        if (!is_rd && !exp_err) begin
            mask = 32'h0;
            for (int b = 0; b < 4; b++) if (ws[b]) mask = mask | (32'hFF << (8 * b));
            ref_mem[idx] = (ref_mem[idx] & ~mask) | (wd & mask);
        end
        @(negedge clk);
        chk("stb_done", {31'b0, wb_stb}, 32'd0);
        chk("ready_done", {31'b0, ready}, 32'd1);
        chk("rvalid", {31'b0, rvalid}, {31'b0, is_rd});
        chk("err", {31'b0, err}, {31'b0, exp_err});
        chk("rdata", rdata, exp_rdata);
        @(negedge clk);
        chk("rvalid_pulse", {31'b0, rvalid}, 32'd0);
        chk("err_pulse", {31'b0, err}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom();
            ref_mem[i] = mem[i];
        end
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_cyc", {31'b0, wb_cyc}, 32'd0);
        chk("rst_stb", {31'b0, wb_stb}, 32'd0);
        chk("rst_we", {31'b0, wb_we}, 32'd0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_adr", wb_adr, 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_sel", {28'b0, wb_sel}, 32'd0);
        arst_n = 1'b1;
        @(negedge clk);

        // Read with same-cycle ack
        mem[3] = 32'hDEAD_BEEF; ref_mem[3] = 32'hDEAD_BEEF;
        xfer(32'h0000_000C, 32'h0, 4'b0000, 0, 1'b0);
        // Write, byte 0, three wait states (ack lands on the last cycle before timeout)
        xfer(32'h0000_0010, 32'h0000_00A5, 4'b0001, 3, 1'b0);
        xfer(32'h0000_0010, 32'h0, 4'b0000, 1, 1'b0);
        // Read answered with error
        xfer(32'h0000_0020, 32'h0, 4'b0000, 2, 1'b1);
        // Write answered with error
        xfer(32'h0000_0024, 32'h1234_5678, 4'b1111, 0, 1'b1);
        // Read that times out, then a late ack in IDLE
        xfer(32'h0000_0028, 32'h0, 4'b0000, 20, 1'b0);
        wb_ack = 1'b1; wb_dat_i = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        wb_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_rvalid", {31'b0, rvalid}, 32'd0);
        chk("late_ack_err", {31'b0, err}, 32'd0);
        chk("late_ack_stb", {31'b0, wb_stb}, 32'd0);
        chk("late_ack_rdata", rdata, exp_rdata);

        // Back-to-back reads with avalid held high
        avalid = 1'b1; addr = 32'h0000_0004; wstrb = 4'b0;
        @(posedge clk);
        #1;
        addr = 32'h0000_0008;
        @(negedge clk);
        chk("b2b_adr1", wb_adr, 32'h0000_0004);
        slave_ack();
        @(posedge clk);
        #1;
        wb_ack = 1'b0;
        @(negedge clk);
        chk("b2b_ready", {31'b0, ready}, 32'd1);
        chk("b2b_rvalid1", {31'b0, rvalid}, 32'd1);
        chk("b2b_rdata1", rdata, ref_mem[1]);
        @(posedge clk);
        #1;
        avalid = 1'b0;
        @(negedge clk);
        chk("b2b_stb2", {31'b0, wb_stb}, 32'd1);
        chk("b2b_adr2", wb_adr, 32'h0000_0008);
        chk("b2b_rvalid_gap", {31'b0, rvalid}, 32'd0);
        slave_ack();
        @(posedge clk);
        #1;
        wb_ack = 1'b0;
        @(negedge clk);
        chk("b2b_rvalid2", {31'b0, rvalid}, 32'd1);
        chk("b2b_rdata2", rdata, ref_mem[2]);
        exp_rdata = ref_mem[2];

        // Freeze: cke low over 5 edges with err asserted, which must be ignored
        avalid = 1'b1; addr = 32'h0000_0014; wstrb = 4'b0;
        @(posedge clk);
        #1;
        avalid = 1'b0;
        @(negedge clk);
        chk("frz_stb_pre", {31'b0, wb_stb}, 32'd1);
        @(posedge clk);
        #1;
        cke = 1'b0; wb_err = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("frz_stb", {31'b0, wb_stb}, 32'd1);
            chk("frz_ready", {31'b0, ready}, 32'd0);
            chk("frz_err", {31'b0, err}, 32'd0);
        end
        cke = 1'b1; wb_err = 1'b0;
        slave_ack();
        @(posedge clk);
        #1;
        wb_ack = 1'b0;
        @(negedge clk);
        chk("frz_rvalid", {31'b0, rvalid}, 32'd1);
        chk("frz_err_after", {31'b0, err}, 32'd0);
        chk("frz_rdata", rdata, ref_mem[5]);
        exp_rdata = ref_mem[5];

        // Asynchronous reset mid-transfer
        avalid = 1'b1; addr = 32'h0000_0018; wstrb = 4'b0;
        @(posedge clk);
        #1;
        avalid = 1'b0;
        @(negedge clk);
        chk("ar_stb_pre", {31'b0, wb_stb}, 32'd1);
        arst_n = 1'b0;
        #1;
        chk("ar_cyc", {31'b0, wb_cyc}, 32'd0);
        chk("ar_stb", {31'b0, wb_stb}, 32'd0);
        chk("ar_ready", {31'b0, ready}, 32'd1);
        @(negedge clk);
        arst_n = 1'b1;
        exp_rdata = 32'h0;
        @(negedge clk);
        chk("ar_rvalid", {31'b0, rvalid}, 32'd0);
        chk("ar_err", {31'b0, err}, 32'd0);
        chk("ar_rdata", rdata, 32'h0);

        // Randomized transfers against the model
        for (int n = 0; n < 60; n++) begin
            logic [3:0] ws;
            ws = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
            xfer($urandom(), $urandom(), ws, $urandom_range(0, 5), ($urandom_range(0, 6) == 0));
        end
        // Read back every word to confirm all writes landed
        for (int i = 0; i < 16; i++)
            xfer(32'(i) << 2, 32'h0, 4'b0, $urandom_range(0, 2), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iob_iob2wishbone.md
# iob_iob2wishbone

Bridge from an IOb-bus slave port to a classic Wishbone master port. It is the inverse of our Wishbone-to-IOb bridge: it lets an IOb master, such as a CPU or test driver, reach Wishbone peripherals like the native uart16550 core. Each IOb request is registered and issued as one Wishbone single cycle. Read data comes back on the IOb response channel. A cycle counter aborts a transfer that never receives an acknowledge.

## Interface
- ADDR_W, 32, address width on both buses
- DATA_W, 32, data width on both buses; multiple of 8
- TIMEOUT, 255, maximum cycles to wait for wb_ack_i/wb_err_i; 0 disables the timeout

Ports:
- clk_i  in  1  clock
- arst_n_i  in  1  asynchronous reset, active-low
- cke_i  in  1  clock enable; when low, all state holds
- iob_avalid_i  in  1  request valid
- iob_addr_i  in  ADDR_W  request address
- iob_wdata_i  in  DATA_W  write data
- iob_wstrb_i  in  DATA_W/8  byte strobes; nonzero means write, zero means read
- iob_ready_o  out  1  request accepted when high together with iob_avalid_i
- iob_rvalid_o  out  1  read data valid, one-cycle pulse
- iob_rdata_o  out  DATA_W  read data
- iob_err_o  out  1  one-cycle pulse: transfer ended by wb_err_i or by timeout
- wb_adr_o  out  ADDR_W  Wishbone address
- wb_dat_o  out  DATA_W  Wishbone write data
- wb_sel_o  out  DATA_W/8  Wishbone byte select
- wb_we_o  out  1  Wishbone write enable
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_dat_i  in  DATA_W  Wishbone read data
- wb_ack_i  in  1  Wishbone acknowledge
- wb_err_i  in  1  Wishbone error

## Operation
- FSM states: IDLE and BUS.
- iob_ready_o is high exactly when the state is IDLE.
- IDLE, on iob_avalid_i:
  - register addr, wdata and wstrb;
  - wb_we_o = |iob_wstrb_i;
  - wb_sel_o = iob_wstrb_i for a write, all ones for a read;
  - clear the timeout counter; go to BUS.
- BUS:
  - wb_cyc_o = wb_stb_o = 1; address, data, select and we are held stable.
  - On wb_ack_i: go to IDLE. If the transfer is a read, capture wb_dat_i into iob_rdata_o and pulse iob_rvalid_o.
  - On wb_err_i, or wb_err_i together with wb_ack_i: go to IDLE. iob_rdata_o = all ones, and iob_rvalid_o pulses if the transfer is a read. iob_err_o pulses in both cases.
  - Timeout: when TIMEOUT is nonzero and the counter reaches TIMEOUT with no ack or err, behave exactly as on error. The counter is $clog2(TIMEOUT+1) bits and saturates.
- Writes produce no iob_rvalid_o pulse. A write reports only through iob_err_o.
- wb_ack_i and wb_err_i are ignored outside BUS.
- iob_rdata_o holds its value until the next read completes.
- cke_i low: FSM, counter and all output registers freeze, and pending ack/err are not sampled. Wishbone slaves must therefore hold ack while cke_i is low.

## Timing
- All outputs are registered.
- Reset values:
  - iob_ready_o = 1;
  - iob_rvalid_o, iob_err_o, wb_cyc_o, wb_stb_o and wb_we_o = 0;
  - iob_rdata_o, wb_adr_o, wb_dat_o and wb_sel_o = 0;
  - state = IDLE.
- Request accepted at cycle T: wb_cyc_o and wb_stb_o are high from T+1.
- Ack sampled at cycle A ≥ T+1:
  - at A+1, wb_cyc_o and wb_stb_o are 0, iob_ready_o is 1, and iob_rvalid_o/iob_rdata_o are valid;
  - a new request may be accepted at A+1.
- Minimum latency, with a combinational ack: request at T, rvalid at T+2. Peak throughput is one transfer per 2 cycles.
- Timeout abort: stb is high for exactly TIMEOUT cycles, then cyc, stb and ready update on the following cycle.
- Asynchronous reset asserted mid-transfer drops wb_cyc_o and wb_stb_o immediately. No rvalid or err pulse is produced, and the transfer is lost.

## Test plan
- Read, slave acks in the same cycle as stb, wb_dat_i=0xDEADBEEF:
  - iob_avalid at T;
  - required: wb_stb_o high only at T+1, iob_rvalid_o=1 at T+2 with iob_rdata_o=0xDEADBEEF, iob_ready_o=1 at T+2.
- Write, addr=0x10, wdata=0x000000A5, wstrb=4'b0001, ack after 3 wait cycles:
  - required: wb_we_o=1 and wb_sel_o=4'b0001 held stable for 4 cycles of stb, no rvalid, ready returns 1 the cycle after ack.
- Back-to-back: two reads issued with avalid held high:
  - required: the second is accepted the cycle after the first ack, and both data words return in order.
- Error: read answered by wb_err_i:
  - required: iob_rvalid_o and iob_err_o pulse together, with iob_rdata_o=0xFFFFFFFF.
- Timeout with TIMEOUT=4 and no ack:
  - required: stb high for 4 cycles, then iob_err_o pulses and ready=1. A late ack arriving afterwards is ignored.
- Freeze and reset:
  - cke_i low for 5 cycles during BUS: state and stb hold.
  - arst_n_i asserted mid-BUS: wb_cyc_o drops to 0 asynchronously and iob_ready_o=1.
